// File: rtl/mem_bank_prog_seq.sv
// mem_bank_prog_seq: sequenced BL/WL programming controller.
// Optional read-back path: define MEM_BANK_PROG_READBACK_EN.
module mem_bank_prog_seq #(
  parameter int NUM_BL       = 19,
  parameter int NUM_WL       = 19,
  parameter int BL_ADDR_W    = 5,
  parameter int WL_ADDR_W    = 5,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1,
  parameter int CNT_W        = 8
) (
  input  logic                 prog_clk,
  input  logic                 prog_reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [BL_ADDR_W-1:0] req_bl_addr,
  input  logic [WL_ADDR_W-1:0] req_wl_addr,
  input  logic                 req_data,
  output logic [0:NUM_BL-1]    bl_en,
  output logic [0:NUM_BL-1]    bl_data,
  output logic [0:NUM_WL-1]    wl_out,
  output logic                 busy,
  output logic                 done,
`ifdef MEM_BANK_PROG_READBACK_EN
  output logic                 err,
  input  logic [0:NUM_BL-1]    sense_in,
  output logic                 rb_data
`else
  output logic                 err
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] PULSE = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  =
    CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  localparam logic [BL_ADDR_W:0] BL_LIM = (BL_ADDR_W+1)'(NUM_BL);
  localparam logic [WL_ADDR_W:0] WL_LIM = (WL_ADDR_W+1)'(NUM_WL);

  logic [1:0]           state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [BL_ADDR_W-1:0] bl_q, bl_n;
  logic [WL_ADDR_W-1:0] wl_q, wl_n;
  logic                 dat_q, dat_n;
  logic                 done_n, err_n, last_pulse;
  logic                 bad_req;
  logic [0:NUM_BL-1]    bl_en_n, bl_data_n;
  logic [0:NUM_WL-1]    wl_out_n;

  assign req_ready = (state == IDLE) && !prog_reset;

  assign bad_req = ({1'b0, req_bl_addr} >= BL_LIM) ||
                   ({1'b0, req_wl_addr} >= WL_LIM);

  // Phase sequencing: each phase loads its length-1 and counts to 0.
  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bl_n       = bl_q;
    wl_n       = wl_q;
    dat_n      = dat_q;
    done_n     = 1'b0;
    err_n      = 1'b0;
    last_pulse = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req) begin
            err_n = 1'b1;
          end else begin
            state_n = SETUP;
            cnt_n   = SETUP_LD;
            bl_n    = req_bl_addr;
            wl_n    = req_wl_addr;
            dat_n   = req_data;
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = PULSE_LD;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      PULSE: begin
        if (cnt == '0) begin
          last_pulse = 1'b1;
          if (HOLD_CYCLES == 0) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = HOLD;
            cnt_n   = HOLD_LD;
          end
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Decode next-cycle line drives so the outputs can be registered.
  always_comb begin
    bl_en_n   = '0;
    bl_data_n = '0;
    wl_out_n  = '0;
    for (int i = 0; i < NUM_BL; i++) begin
      if (state_n != IDLE && bl_n == BL_ADDR_W'(i)) begin
        bl_en_n[i]   = 1'b1;
        bl_data_n[i] = dat_n;
      end
    end
    for (int i = 0; i < NUM_WL; i++) begin
      if (state_n == PULSE && wl_n == WL_ADDR_W'(i)) begin
        wl_out_n[i] = 1'b1;
      end
    end
  end

  // State, latched request and registered outputs.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bl_q    <= '0;
      wl_q    <= '0;
      dat_q   <= 1'b0;
      bl_en   <= '0;
      bl_data <= '0;
      wl_out  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bl_q    <= bl_n;
      wl_q    <= wl_n;
      dat_q   <= dat_n;
      bl_en   <= bl_en_n;
      bl_data <= bl_data_n;
      wl_out  <= wl_out_n;
      busy    <= (state_n != IDLE);
      done    <= done_n;
      err     <= err_n;
    end
  end

`ifdef MEM_BANK_PROG_READBACK_EN
  logic rb_cap;
  logic sense_bit;

  // bl_en is one-hot on the addressed line throughout PULSE.
  assign sense_bit = |(sense_in & bl_en);

  // Capture sense on the last PULSE cycle; publish it with done.
  always_ff @(posedge prog_clk) begin
    if (prog_reset) begin
      rb_cap  <= 1'b0;
      rb_data <= 1'b0;
    end else begin
      if (last_pulse) begin
        rb_cap <= sense_bit;
      end
      if (done_n) begin
        rb_data <= (state == PULSE) ? sense_bit : rb_cap;
      end
    end
  end
`endif

endmodule

// File: doc/mem_bank_prog_seq.md
Name: mem_bank_prog_seq

Overview:
- Sequenced BL/WL programming controller for the memory-bank configuration array.
- Accepts one write request per handshake: BL address, WL address and data bit.
- Drives the addressed bit line, then pulses the addressed word line with programmable setup, pulse and hold phases.
- Generalises the combinational BL/WL decoders to parametrised array size, timed write phases and request/done/error handshakes.

Parameters:
- NUM_BL, 19, number of bit lines (1..2**BL_ADDR_W)
- NUM_WL, 19, number of word lines (1..2**WL_ADDR_W)
- BL_ADDR_W, 5, BL address width
- WL_ADDR_W, 5, WL address width
- SETUP_CYCLES, 1, cycles BL is driven before the WL pulse (>=1)
- PULSE_CYCLES, 2, cycles WL is held high (>=1)
- HOLD_CYCLES, 1, cycles BL is held after the WL falls (>=0)
- CNT_W, 8, phase counter width; every *_CYCLES value must be < 2**CNT_W

Ports:
- prog_clk  input  1  programming clock; all logic on its rising edge
- prog_reset  input  1  synchronous, active-high reset
- req_valid  input  1  write request valid
- req_ready  output  1  controller can accept a request
- req_bl_addr  input  BL_ADDR_W  target bit line
- req_wl_addr  input  WL_ADDR_W  target word line
- req_data  input  1  value to program
- bl_en  output  [0:NUM_BL-1]  one-hot; marks the driven bit line
- bl_data  output  [0:NUM_BL-1]  data on the driven bit line; 0 elsewhere
- wl_out  output  [0:NUM_WL-1]  one-hot word-line pulse
- busy  output  1  write sequence in progress
- done  output  1  one-cycle pulse when a write completes
- err  output  1  one-cycle pulse when an out-of-range request is rejected

Behaviour:
- Reset: the clock is prog_clk; reset is prog_reset, synchronous and active-high. On the first rising edge with prog_reset=1:
  - state goes to IDLE; counter and latched request are cleared.
  - bl_en, bl_data, wl_out, busy, done and err all become 0.
  - req_ready becomes 1 after reset is released.
- Reset mid-sequence aborts the write: WL drops to 0 at that edge and no done is issued.
- Outputs are registered. req_ready = (state==IDLE) && !prog_reset.
- Accept: req_valid && req_ready at edge T latches the address and data.
- Range check: if req_bl_addr>=NUM_BL or req_wl_addr>=NUM_WL:
  - err=1 during cycle T+1; state stays IDLE, req_ready stays 1.
  - No BL or WL activity.
- Valid request, state machine IDLE -> SETUP -> PULSE -> HOLD -> IDLE:
  - SETUP (cycles T+1 .. T+SETUP_CYCLES): bl_en[addr]=1, bl_data[addr]=data, wl_out=0, busy=1.
  - PULSE (next PULSE_CYCLES cycles): BL unchanged, wl_out[wl_addr]=1.
  - HOLD (next HOLD_CYCLES cycles): wl_out=0, BL unchanged. When HOLD_CYCLES=0, HOLD is skipped.
  - Return to IDLE: bl_en and bl_data clear; done=1 for exactly the first IDLE cycle; busy=0.
- Latency: accept to done = SETUP_CYCLES + PULSE_CYCLES + HOLD_CYCLES + 1 cycles.
- Back-to-back: a request may be accepted in the same cycle that done is high, because req_ready=1 in that cycle. The next SETUP starts the following cycle.
- Signal invariants:
  - wl_out is never asserted unless bl_en is asserted for the same line set.
  - At most one bl_en bit and one wl_out bit are high at any time.
- Request inputs are ignored outside IDLE. They do not need to be held stable after acceptance.
- Counter: loads (phase length − 1) on each phase entry and decrements to 0; no wrap-around.

Optional Feature:
- Macro: MEM_BANK_PROG_READBACK_EN.
- When defined, two extra ports are added:
  - sense_in  input  [0:NUM_BL-1]: sense-amp outputs.
  - rb_data  output  1: read-back value.
- Read-back behaviour:
  - On the last PULSE cycle, sense_in[bl_addr] is registered.
  - rb_data presents that value in the done cycle and holds it until the next done.
  - Reset clears rb_data to 0.
- When not defined, these ports and the logic behind them do not exist; all other behaviour is identical.

Test Plan:
- Reset mid-PULSE: assert prog_reset with wl_out[3]=1 -> next edge all outputs 0, req_ready=1 after release, no done pulse.
- Basic write with defaults: accept bl=4, wl=7, data=1 at cycle 0:
  - bl_en[4]=bl_data[4]=1 during cycles 1-4.
  - wl_out[7]=1 during cycles 2-3.
  - done=1 at cycle 5; all other bits 0 throughout.
- Out of range: accept bl=19, wl=0 -> err=1 for one cycle, no BL/WL activity, req_ready remains 1.
- Back-to-back: hold req_valid high with two requests (bl=0/wl=0/data=0, then bl=18/wl=18/data=1) -> second accepted in the done cycle of the first, then wl_out[18] pulses 2 cycles.
- Parameter sweep with SETUP=3, PULSE=1, HOLD=0 -> wl high only at cycle 4, done at cycle 5, HOLD never entered.
- With MEM_BANK_PROG_READBACK_EN: sense_in[4]=1 during PULSE -> rb_data=1 in the done cycle; next write with sense 0 -> rb_data becomes 0.
